// File: rtl/sparc_exu_alu_arbctl_if.sv
// Bus bundle between the IFU/ECL decode side and the EXU ALU arbiter.
// D-stage requests from the integer pipe and the aux mul/div engine
// enter here, and the E-stage ALU controls leave here.
// Optional performance port: SPARC_EXU_ALU_ARB_PERF_EN.
interface sparc_exu_alu_arbctl_if;
   logic        pipe_vld_d;
   logic [2:0]  pipe_op_d;
   logic        pipe_inv_d;
   logic        pipe_cin_d;
   logic        aux_req;
   logic        aux_sub;
   logic        arb_pipe_stall_d;
   logic        arb_aux_gnt;
   logic        arb_aux_own_e;
   logic        arb_vld_e;
   logic        ecl_alu_log_sel_and_e;
   logic        ecl_alu_log_sel_or_e;
   logic        ecl_alu_log_sel_xor_e;
   logic        ecl_alu_log_sel_move_e;
   logic        ecl_alu_out_sel_sum_e_l;
   logic        ecl_alu_out_sel_rs3_e_l;
   logic        ecl_alu_out_sel_shift_e_l;
   logic        ecl_alu_out_sel_logic_e_l;
   logic        ecl_alu_cin_e;
   logic        ifu_exu_invert_d;
`ifdef SPARC_EXU_ALU_ARB_PERF_EN
   logic        arb_perf_clr;
   logic [15:0] arb_perf_cnt;
`endif

   modport master (
      output pipe_vld_d, pipe_op_d, pipe_inv_d, pipe_cin_d, aux_req, aux_sub,
`ifdef SPARC_EXU_ALU_ARB_PERF_EN
      output arb_perf_clr,
      input  arb_perf_cnt,
`endif
      input  arb_pipe_stall_d, arb_aux_gnt, arb_aux_own_e, arb_vld_e,
      input  ecl_alu_log_sel_and_e, ecl_alu_log_sel_or_e,
      input  ecl_alu_log_sel_xor_e, ecl_alu_log_sel_move_e,
      input  ecl_alu_out_sel_sum_e_l, ecl_alu_out_sel_rs3_e_l,
      input  ecl_alu_out_sel_shift_e_l, ecl_alu_out_sel_logic_e_l,
      input  ecl_alu_cin_e, ifu_exu_invert_d
   );

   modport slave (
      input  pipe_vld_d, pipe_op_d, pipe_inv_d, pipe_cin_d, aux_req, aux_sub,
`ifdef SPARC_EXU_ALU_ARB_PERF_EN
      input  arb_perf_clr,
      output arb_perf_cnt,
`endif
      output arb_pipe_stall_d, arb_aux_gnt, arb_aux_own_e, arb_vld_e,
      output ecl_alu_log_sel_and_e, ecl_alu_log_sel_or_e,
      output ecl_alu_log_sel_xor_e, ecl_alu_log_sel_move_e,
      output ecl_alu_out_sel_sum_e_l, ecl_alu_out_sel_rs3_e_l,
      output ecl_alu_out_sel_shift_e_l, ecl_alu_out_sel_logic_e_l,
      output ecl_alu_cin_e, ifu_exu_invert_d
   );
endinterface

// File: rtl/sparc_exu_alu_arbctl.sv
// EXU ALU arbiter: shares the ALU between the integer pipe and the aux
// mul/div step engine. Pipe has priority; aux is forced through after
// STARVE_MAX consecutive denials. The D-stage decision registers into E.
// Optional FORCE-cycle performance counter: SPARC_EXU_ALU_ARB_PERF_EN.
module sparc_exu_alu_arbctl #(
   parameter int STARVE_MAX = 4,
   parameter int CNTW       = 3
) (
   input  logic                  rclk,
   input  logic                  arst_l,
   sparc_exu_alu_arbctl_if.slave bus
);

   typedef enum logic [0:0] {PIPE_PRI = 1'b0, FORCE = 1'b1} state_t;

   localparam logic [CNTW-1:0] STARVE_LAST = CNTW'(STARVE_MAX - 1);

   // One-hot output select, active high internally: [0]sum [1]rs3 [2]shift [3]logic
   localparam logic [3:0] SEL_SUM   = 4'b0001;
   localparam logic [3:0] SEL_RS3   = 4'b0010;
   localparam logic [3:0] SEL_SHIFT = 4'b0100;
   localparam logic [3:0] SEL_LOGIC = 4'b1000;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_MOV   = 3'b101;
   localparam logic [2:0] OP_SHIFT = 3'b110;
   localparam logic [2:0] OP_RS3   = 3'b111;

   state_t          state_r, state_nxt_s;
   logic [CNTW-1:0] cnt_r, cnt_nxt_s;
   logic            gnt_s, stall_s, pipe_win_s;
   logic            vld_nxt_s, own_nxt_s, cin_nxt_s, inv_s;
   logic [3:0]      sel_nxt_s, log_nxt_s;   // log: [3]and [2]or [1]xor [0]move
   logic            vld_e_r, own_e_r, cin_e_r;
   logic [3:0]      sel_r, log_r, out_l_s;

   // Arbitration and starvation tracking for the D-stage requesters
   always_comb begin
      state_nxt_s = PIPE_PRI;
      cnt_nxt_s   = '0;
      gnt_s       = 1'b0;
      stall_s     = 1'b0;
      pipe_win_s  = 1'b0;
      case (state_r)
         PIPE_PRI: begin
            if (bus.pipe_vld_d) begin
               pipe_win_s = 1'b1;
               if (bus.aux_req) begin
                  cnt_nxt_s = cnt_r + CNTW'(1);
                  if (cnt_r == STARVE_LAST) begin
                     state_nxt_s = FORCE;
                  end else begin
                     state_nxt_s = PIPE_PRI;
                  end
               end else begin
                  cnt_nxt_s = '0;
               end
            end else if (bus.aux_req) begin
               gnt_s = 1'b1;
            end else begin
               gnt_s = 1'b0;
            end
         end
         FORCE: begin
            // Pipe is held off for one cycle regardless of its request
            gnt_s   = bus.aux_req;
            stall_s = 1'b1;
         end
         default: begin
            state_nxt_s = PIPE_PRI;
         end
      endcase
   end

   // Decode the D-stage winner into next E-stage ALU controls
   always_comb begin
      vld_nxt_s = 1'b0;
      own_nxt_s = 1'b0;
      cin_nxt_s = 1'b0;
      inv_s     = 1'b0;
      sel_nxt_s = SEL_SUM;
      log_nxt_s = 4'b0000;
      if (gnt_s) begin
         vld_nxt_s = 1'b1;
         own_nxt_s = 1'b1;
         cin_nxt_s = bus.aux_sub;
         inv_s     = bus.aux_sub;
      end else if (pipe_win_s) begin
         vld_nxt_s = 1'b1;
         case (bus.pipe_op_d)
            OP_ADD:   cin_nxt_s = bus.pipe_cin_d;
            OP_SUB:   begin cin_nxt_s = 1'b1; inv_s = 1'b1; end
            OP_AND:   begin sel_nxt_s = SEL_LOGIC; log_nxt_s = 4'b1000; inv_s = bus.pipe_inv_d; end
            OP_OR:    begin sel_nxt_s = SEL_LOGIC; log_nxt_s = 4'b0100; inv_s = bus.pipe_inv_d; end
            OP_XOR:   begin sel_nxt_s = SEL_LOGIC; log_nxt_s = 4'b0010; inv_s = bus.pipe_inv_d; end
            OP_MOV:   begin sel_nxt_s = SEL_LOGIC; log_nxt_s = 4'b0001; end
            OP_SHIFT: sel_nxt_s = SEL_SHIFT;
            OP_RS3:   sel_nxt_s = SEL_RS3;
            default:  sel_nxt_s = SEL_SUM;
         endcase
      end else begin
         vld_nxt_s = 1'b0;
      end
   end

   // FSM, starvation counter and E-stage control registers
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         state_r <= PIPE_PRI;
         cnt_r   <= '0;
         vld_e_r <= 1'b0;
         own_e_r <= 1'b0;
         cin_e_r <= 1'b0;
         sel_r   <= SEL_SUM;
         log_r   <= 4'b0000;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         vld_e_r <= vld_nxt_s;
         own_e_r <= own_nxt_s;
         cin_e_r <= cin_nxt_s;
         sel_r   <= sel_nxt_s;
         log_r   <= log_nxt_s;
      end
   end

   // Active-low output selects; any non-one-hot code falls back to sum
   always_comb begin
      out_l_s = ~SEL_SUM;
      case (sel_r)
         SEL_SUM:   out_l_s = ~SEL_SUM;
         SEL_RS3:   out_l_s = ~SEL_RS3;
         SEL_SHIFT: out_l_s = ~SEL_SHIFT;
         SEL_LOGIC: out_l_s = ~SEL_LOGIC;
         default:   out_l_s = ~SEL_SUM;
      endcase
   end

   assign bus.arb_pipe_stall_d          = stall_s;
   assign bus.arb_aux_gnt               = gnt_s;
   assign bus.ifu_exu_invert_d          = inv_s;
   assign bus.arb_vld_e                 = vld_e_r;
   assign bus.arb_aux_own_e             = own_e_r;
   assign bus.ecl_alu_cin_e             = cin_e_r;
   assign bus.ecl_alu_log_sel_and_e     = log_r[3];
   assign bus.ecl_alu_log_sel_or_e      = log_r[2];
   assign bus.ecl_alu_log_sel_xor_e     = log_r[1];
   assign bus.ecl_alu_log_sel_move_e    = log_r[0];
   assign bus.ecl_alu_out_sel_sum_e_l   = out_l_s[0];
   assign bus.ecl_alu_out_sel_rs3_e_l   = out_l_s[1];
   assign bus.ecl_alu_out_sel_shift_e_l = out_l_s[2];
   assign bus.ecl_alu_out_sel_logic_e_l = out_l_s[3];

`ifdef SPARC_EXU_ALU_ARB_PERF_EN
   logic [15:0] perf_r;

   // Saturating count of FORCE cycles; synchronous clear wins over increment
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         perf_r <= 16'h0000;
      end else if (bus.arb_perf_clr) begin
         perf_r <= 16'h0000;
      end else if ((state_r == FORCE) && (perf_r != 16'hFFFF)) begin
         perf_r <= perf_r + 16'h0001;
      end else begin
         perf_r <= perf_r;
      end
   end

   assign bus.arb_perf_cnt = perf_r;
`endif

endmodule

// File: doc/sparc_exu_alu_arbctl.md
Name: sparc_exu_alu_arbctl

Overview:
- Sequences the shared EXU ALU (adder, logic, shifter-pass and rs3-pass output mux) between two requesters: the integer pipe (D-stage decode) and the auxiliary long-latency unit (mul/div step engine).
- Registers the winning request D→E and drives the ALU's E-stage control: active-high logic selects, active-low one-hot output selects, cin, invert.
- Applies starvation control so aux is guaranteed forward progress.
- Sits between IFU/ECL decode and the ALU datapath.

Parameters:
- STARVE_MAX, 4, consecutive cycles aux may be denied before a forced grant (legal range 1..7).
- CNTW, 3, width of the starvation counter.

Ports:
- rclk  in  1  clock
- arst_l  in  1  asynchronous active-low reset
- pipe_vld_d  in  1  pipe ALU op valid in D
- pipe_op_d  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV, 110 SHIFT, 111 RS3
- pipe_inv_d  in  1  invert rs2 for logic ops (andn/orn/xnor)
- pipe_cin_d  in  1  carry-in request (ADDC)
- aux_req  in  1  aux requests one adder cycle (level, held until granted)
- aux_sub  in  1  aux op is SUB (else ADD)
- arb_pipe_stall_d  out  1  pipe op in D not accepted this cycle
- arb_aux_gnt  out  1  single-cycle grant; aux op issues to E next cycle
- arb_aux_own_e  out  1  E-stage result belongs to aux
- arb_vld_e  out  1  E-stage op valid
- ecl_alu_log_sel_and_e / _or_e / _xor_e / _move_e  out  1 each  logic selects, active high
- ecl_alu_out_sel_sum_e_l / _rs3_e_l / _shift_e_l / _logic_e_l  out  1 each  output selects, active low, exactly one low
- ecl_alu_cin_e  out  1  adder carry-in
- ifu_exu_invert_d  out  1  invert to ALU, D-timed

Behaviour:
- Reset (arst_l=0, asynchronous): FSM=PIPE_PRI, counter=0, arb_vld_e=0, arb_aux_own_e=0, arb_aux_gnt=0, arb_pipe_stall_d=0. Output selects reset to sum (sum_e_l=0, others 1); logic selects 0; cin 0; invert 0.
- Arbitration is combinational in D; the decision registers into E. Latency from grant to E-stage controls is 1 cycle.
- FSM states:
  - PIPE_PRI: pipe wins when both request. A denied aux increments the counter. When counter == STARVE_MAX-1 and aux is denied again, go to FORCE.
  - FORCE: aux granted unconditionally, pipe stalled (arb_pipe_stall_d=1), counter cleared, return to PIPE_PRI next cycle.
- Aux alone: granted immediately, counter cleared.
- Any aux grant clears the counter. aux_req low also clears it.
- Neither requester valid: arb_vld_e=0 next cycle. Output selects hold sum; logic selects 0.
- Decode into E:
  - ADD/SUB: sum select; cin = pipe_cin_d for ADD; cin = 1 and invert = 1 for SUB.
  - AND/OR/XOR: logic select plus the matching log_sel; invert = pipe_inv_d.
  - MOV: logic select, move.
  - SHIFT: shift select.
  - RS3: rs3 select.
  - Aux ADD/SUB: same as pipe ADD/SUB with cin = aux_sub and invert = aux_sub.
- ifu_exu_invert_d is driven combinationally from the D-stage winner, because the ALU flops it internally.
- A stalled pipe op must be held by the source; the block keeps no pipe buffer.
- Reset asserted mid-operation: the E-stage op is killed (arb_vld_e=0) and the counter is cleared. No grant is pending after deassert.
- Output selects are one-hot by construction. An illegal state falls back to sum select.

Optional Feature:
- Macro: SPARC_EXU_ALU_ARB_PERF_EN.
- Defined:
  - Adds output arb_perf_cnt (16 bits): counts FORCE-state cycles.
  - Saturates at 0xFFFF; cleared by arst_l.
  - Adds input arb_perf_clr (synchronous clear, priority over increment in the same cycle).
- Undefined: neither port nor counter exists; arbitration behaviour is identical either way.

Test Plan:
- Reset: hold arst_l=0, deassert → vld_e=0, sum_e_l=0, rs3/shift/logic_e_l=1, cin=0, gnt=0.
- Pipe only: pipe_vld_d=1, op=001 (SUB) → next cycle vld_e=1, own_e=0, sum_e_l=0, cin_e=1; invert_d=1 in the issue cycle.
- Aux only: aux_req=1, aux_sub=0 → gnt=1 same cycle; next cycle own_e=1, sum select, cin_e=0.
- Starvation: pipe_vld_d=1 and aux_req=1 continuously, STARVE_MAX=4 → pipe wins cycles 0-3; cycle 4 gnt=1 and stall_d=1; cycle 5 pipe resumes; pattern repeats with period 5.
- Decode sweep: ops 010..111, pipe_inv_d=1 for AND → exactly one *_e_l low per op; AND gives log_sel_and_e=1 and invert_d=1; MOV gives move=1; SHIFT gives shift_e_l=0; RS3 gives rs3_e_l=0.
- Mid-op reset: assert arst_l during FORCE → counter 0, vld_e=0 immediately (asynchronous). With SPARC_EXU_ALU_ARB_PERF_EN, arb_perf_cnt=0; after 3 forced cycles it reads 3; arb_perf_clr asserted in the same cycle as a force leaves 0.
